seg7_io_driver: RTL and testbench

Memory-mapped 8-digit multiplexed seven-segment display peripheral on the CPU IO bus, downstream of the memory/IO address decoder alongside the LED and switch drivers. It takes halfword IO writes from store instructions when its chip-select is active. It holds 32 bits of hex display data plus control and blink registers, and time-multiplexes the 8 common-anode digits with a refresh prescaler. It provides combinational readback so load instructions complete in a single cycle.

---
 rtl/seg7_io_driver.sv | 163 ++++++++++++++++
 tb/tb_seg7_io_driver.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_io_driver.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : seg7_io_driver
// Purpose  : Memory-mapped 8-digit multiplexed seven-segment display driver.
//            Holds 32 bits of hex digit data, a digit-enable / decimal-point
//            control register and a blink mask. It scans the common-anode
//            digits with a refresh prescaler and provides combinational
//            readback, so loads complete in a single cycle.
// Ports    : clock      - CPU clock
//            rst        - synchronous active-high reset
//            seg_cs     - chip select from the IO address decoder
//            seg_write  - IO write strobe (halfword stores)
//            seg_read   - IO read strobe
//            seg_addr   - byte offset: 0 DATA_LO, 2 DATA_HI, 4 CTRL, 6 BLINK
//            seg_wdata  - write data (low halfword of the store data)
//            seg_rdata  - combinational readback data
//            seg_an     - digit anodes, active-low, bit i = digit i
//            seg_out    - segments, active-low, [7]=dp, [6:0]=g..a
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module seg7_io_driver #(
    parameter int SCAN_DIV    = 100000,  // clock cycles per digit slot (>= 2)
    parameter int BLINK_TICKS = 256      // scan ticks per blink half-period (>= 1)
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        seg_cs,
    input  logic        seg_write,
    input  logic        seg_read,
    input  logic [2:0]  seg_addr,
    input  logic [15:0] seg_wdata,
    output logic [15:0] seg_rdata,
    output logic [7:0]  seg_an,
    output logic [7:0]  seg_out
);

    localparam int c_PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int c_BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(SCAN_DIV - 1);
    localparam logic [c_BW-1:0] c_BLINK_MAX = c_BW'(BLINK_TICKS - 1);

    // Register offsets (byte addresses, halfword aligned)
    localparam logic [1:0] c_REG_DATA_LO = 2'd0;
    localparam logic [1:0] c_REG_DATA_HI = 2'd1;
    localparam logic [1:0] c_REG_CTRL    = 2'd2;
    localparam logic [1:0] c_REG_BLINK   = 2'd3;

    logic [31:0]     r_data;
    logic [15:0]     r_ctrl;
    logic [7:0]      r_blink;
    logic [c_PW-1:0] r_presc;
    logic [2:0]      r_idx;
    logic [c_BW-1:0] r_bcnt;
    logic            r_phase;   // 1 = blinking digits are off
    logic [7:0]      r_an;
    logic [7:0]      r_out;

    logic            w_tick;
    logic            w_wr;
    logic [3:0]      w_nib;
    logic            w_lit;
    logic [7:0]      w_an;
    logic [7:0]      w_out;

    // Active-low g..a pattern for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    assign w_tick = (r_presc == c_PRESC_MAX);
    assign w_wr   = seg_cs & seg_write & ~seg_addr[0];

    // Bus register file. Odd offsets never write.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_data  <= 32'h0;
            r_ctrl  <= 16'h0;
            r_blink <= 8'h0;
        end else if (w_wr) begin
            case (seg_addr[2:1])
                c_REG_DATA_LO: r_data[15:0]  <= seg_wdata;
                c_REG_DATA_HI: r_data[31:16] <= seg_wdata;
                c_REG_CTRL:    r_ctrl        <= seg_wdata;
                default:       r_blink       <= seg_wdata[7:0];
            endcase
        end
    end

    // Refresh prescaler, digit scan index and blink timing.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= 3'd0;
            r_bcnt  <= '0;
            r_phase <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
                r_idx <= r_idx + 3'd1;
                if (r_bcnt == c_BLINK_MAX) begin
                    r_bcnt  <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_bcnt <= r_bcnt + 1'b1;
                end
            end
        end
    end

    // Digit decode for the current slot; registered below so the pins are
    // glitch-free and always lag the index/registers by exactly one cycle.
    assign w_nib = r_data[{r_idx, 2'b00} +: 4];
    assign w_lit = r_ctrl[r_idx] & ~(r_blink[r_idx] & r_phase);
    assign w_an  = w_lit ? ~(8'b1 << r_idx) : 8'hFF;
    assign w_out = w_lit ? {~r_ctrl[{1'b1, r_idx}], hex_to_seg(w_nib)} : 8'hFF;

    always_ff @(posedge clock) begin
        if (rst) begin
            r_an  <= 8'hFF;
            r_out <= 8'hFF;
        end else begin
            r_an  <= w_an;
            r_out <= w_out;
        end
    end

    assign seg_an  = r_an;
    assign seg_out = r_out;

    // Combinational readback; odd offsets and deselected reads return zero.
    always_comb begin
        seg_rdata = 16'h0000;
        if (seg_cs && seg_read && !seg_addr[0]) begin
            case (seg_addr[2:1])
                c_REG_DATA_LO: seg_rdata = r_data[15:0];
                c_REG_DATA_HI: seg_rdata = r_data[31:16];
                c_REG_CTRL:    seg_rdata = r_ctrl;
                default:       seg_rdata = {8'h00, r_blink};
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_io_driver.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_seg7_io_driver
// Purpose  : Self-checking bench for seg7_io_driver. Directed bus sequences
//            followed by random bus traffic, compared every cycle against a
//            time-based behavioural model of the display.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_seg7_io_driver;

    localparam int SCAN_DIV    = 4;
    localparam int BLINK_TICKS = 16;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        seg_cs = 1'b0;
    logic        seg_write = 1'b0;
    logic        seg_read = 1'b0;
    logic [2:0]  seg_addr = 3'd0;
    logic [15:0] seg_wdata = 16'h0;
    logic [15:0] seg_rdata;
    logic [7:0]  seg_an;
    logic [7:0]  seg_out;

    seg7_io_driver #(
        .SCAN_DIV    (SCAN_DIV),
        .BLINK_TICKS (BLINK_TICKS)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .seg_cs    (seg_cs),
        .seg_write (seg_write),
        .seg_read  (seg_read),
        .seg_addr  (seg_addr),
        .seg_wdata (seg_wdata),
        .seg_rdata (seg_rdata),
        .seg_an    (seg_an),
        .seg_out   (seg_out)
    );

    always #5 clock = ~clock;

    // Model state: per-digit values and masks, plus cycles since reset.
    logic [3:0] m_dig [8];
    logic [7:0] m_en, m_dp, m_bl;
    int         m_t;
    logic [7:0] exp_an, exp_out;
    logic [6:0] hex_tab [16];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_reg(input logic [2:0] a);
        case (a)
            3'd0: return {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
            3'd2: return {m_dig[7], m_dig[6], m_dig[5], m_dig[4]};
            3'd4: return {m_dp, m_en};
            3'd6: return {8'h00, m_bl};
            default: return 16'h0000;
        endcase
    endfunction

    // One bus cycle: drive inputs, check readback, advance the model across
    // the clock edge, then check the display pins.
    task automatic cycle(input logic r, input logic c, input logic w, input logic rd,
                         input logic [2:0] a, input logic [15:0] d);
        int slot, ticks;
        bit phase, lit;
        rst = r; seg_cs = c; seg_write = w; seg_read = rd; seg_addr = a; seg_wdata = d;
        #1;
        check("rdata", seg_rdata, (c && rd) ? model_reg(a) : 16'h0000);
        if (r) begin
            for (int i = 0; i < 8; i++) m_dig[i] = 4'h0;
            m_en = 8'h0; m_dp = 8'h0; m_bl = 8'h0;
            m_t = 0;
            exp_an = 8'hFF; exp_out = 8'hFF;
        end else begin
            ticks = m_t / SCAN_DIV;
            slot  = ticks % 8;
            phase = ((ticks / BLINK_TICKS) % 2) == 1;
            lit   = m_en[slot] && !(m_bl[slot] && phase);
            exp_an  = lit ? (8'hFF & ~(8'd1 << slot)) : 8'hFF;
            exp_out = lit ? {~m_dp[slot], hex_tab[m_dig[slot]]} : 8'hFF;
            if (c && w && !a[0]) begin
                case (a[2:1])
                    2'd0: for (int i = 0; i < 4; i++) m_dig[i]   = d[4*i +: 4];
                    2'd1: for (int i = 0; i < 4; i++) m_dig[i+4] = d[4*i +: 4];
                    2'd2: begin m_en = d[7:0]; m_dp = d[15:8]; end
                    default: m_bl = d[7:0];
                endcase
            end
            m_t++;
        end
        @(posedge clock);
        #1;
        check("seg_an", seg_an, exp_an);
        check("seg_out", seg_out, exp_out);
        check("one_anode", ($countones(~seg_an) <= 1), 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, a, d);
    endtask

    task automatic rd_all();
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1, 3'(i), 16'h0);
    endtask

    initial begin
        hex_tab[0]  = 7'h40; hex_tab[1]  = 7'h79; hex_tab[2]  = 7'h24; hex_tab[3]  = 7'h30;
        hex_tab[4]  = 7'h19; hex_tab[5]  = 7'h12; hex_tab[6]  = 7'h02; hex_tab[7]  = 7'h78;
        hex_tab[8]  = 7'h00; hex_tab[9]  = 7'h10; hex_tab[10] = 7'h08; hex_tab[11] = 7'h03;
        hex_tab[12] = 7'h46; hex_tab[13] = 7'h21; hex_tab[14] = 7'h06; hex_tab[15] = 7'h0E;
        for (int i = 0; i < 8; i++) m_dig[i] = 4'h0;
        m_en = 8'h0; m_dp = 8'h0; m_bl = 8'h0; m_t = 0;
        exp_an = 8'hFF; exp_out = 8'hFF;

        // Reset for three cycles, then all readbacks are zero.
        @(negedge clock);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        rd_all();

        // Full data and all digits enabled with dp on digit 0; scan past a wrap.
        wr(3'd0, 16'h3210);
        wr(3'd2, 16'h7654);
        wr(3'd4, 16'h01FF);
        idle(40);

        // Only digits 0 and 2 enabled.
        wr(3'd4, 16'h0005);
        idle(40);

        // Digit 0 blinking.
        wr(3'd6, 16'h0001);
        wr(3'd4, 16'h0001);
        idle(300);

        // Odd-offset write is ignored; readback gating on chip select.
        wr(3'd1, 16'hFFFF);
        wr(3'd5, 16'hFFFF);
        rd_all();
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 16'h0);
        // Read and write together: old value visible before the edge.
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 3'd4, 16'hA5FF);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 16'h0);

        // Reset while the scan sits on digit 5.
        begin
            int guard = 0;
            while (((m_t / SCAN_DIV) % 8) != 5 && guard < 64) begin
                idle(1);
                guard++;
            end
            check("reach_idx5", ((m_t / SCAN_DIV) % 8), 5);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        rd_all();
        idle(10);

        // Random bus traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            logic r, c, w, rdd;
            r   = ($urandom % 400) == 0;
            c   = ($urandom % 4) != 0;
            w   = ($urandom % 8) == 0;
            rdd = ($urandom % 2) == 1;
            cycle(r, c, w, rdd, 3'($urandom % 8), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
